miner_dispatch: RTL
===================

# miner_dispatch

Round-based nonce scheduler for the multi-core miner. It accepts a mining job, then repeatedly launches all `CORES` hashing cores in lockstep; core i hashes nonce `base_nonce + i`. After each round it advances `base_nonce` by `CORES` until a core reports a hit or the 32-bit nonce space is exhausted. It sits between the top-level job/control logic and the hashing-core array.

## Interface
- `CORES`, default 4: number of hashing cores. Must be a power of two, 1..64.
- `clk`  in  1: system clock, rising edge.
- `n_rst`  in  1: asynchronous active-low reset.
- `job_valid`  in  1: single-cycle request to start a job. Honoured only while `job_ready`=1.
- `job_start_nonce`  in  32: first nonce of the job. Sampled with `job_valid`. The low log2(CORES) bits are forced to 0.
- `abort`  in  1: cancel the running job.
- `job_ready`  out  1: high in IDLE.
- `busy`  out  1: high in ISSUE and WAIT.
- `core_start`  out  CORES: one-cycle launch pulse. All bits are driven identically.
- `base_nonce`  out  32: nonce of core 0 for the current round. Held stable from ISSUE through WAIT.
- `core_done`  in  CORES: per-core completion pulse.
- `core_found`  in  CORES: per-core hit flag. Valid in the same cycle as that core's `core_done`.
- `result_valid`  out  1: one-cycle job-complete pulse.
- `result_found`  out  1: 1 means a hit was found.
- `result_nonce`  out  32: winning nonce, or 0 if there was no hit. Held until the next accepted job.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on `job_valid`.
  - ISSUE → WAIT, always.
  - WAIT → ISSUE: all done, no hit, not the last round.
  - WAIT → REPORT: all done and (hit or last round).
  - REPORT → IDLE, always.
- Job accept: load `base_nonce` = aligned `job_start_nonce`. Clear `result_found` and `result_nonce`.
- ISSUE:
  - Assert `core_start` = all ones.
  - Clear the done mask and the found mask.
  - Capture any `core_done` / `core_found` bits arriving in that same cycle.
- WAIT:
  - OR `core_done` into a sticky done mask.
  - OR `core_done & core_found` into a sticky found mask.
  - The round is complete when the done mask is all ones, evaluated on the combined registered and incoming bits.
- Hit selection: the lowest-index set bit i of the found mask wins. `result_nonce` = `base_nonce + i`.
- Last round: `base_nonce` == 2^32 − CORES, i.e. the stride counter's wrap flag.
- Advance: `base_nonce` += CORES, modulo 2^32. It is updated on the WAIT→ISSUE transition.
- `abort` in ISSUE, WAIT or REPORT:
  - Go to IDLE next cycle. `abort` has priority over round completion.
  - No `result_valid` pulse; result registers are not updated.
  - `abort` in IDLE has no effect.
- `job_valid` outside IDLE is ignored.
- `core_done` in IDLE or REPORT is ignored.
- Reset values: state IDLE, `job_ready`=1. All other outputs 0, including `base_nonce`, both masks, `result_found` and `result_nonce`.

## Timing
- `job_valid` sampled high at edge k → `core_start` high during cycle k+1 (ISSUE).
- Round complete at edge m → next `core_start` during cycle m+1 (ISSUE), or `result_valid` during cycle m+1 (REPORT).
- `job_ready` returns high in cycle m+2.
- Minimum round period: 2 cycles (ISSUE plus one WAIT cycle), for cores that respond combinationally.
- `result_found` and `result_nonce` are valid in the REPORT cycle and held afterwards.
- Reset asserted mid-job: immediate return to IDLE. No `result_valid` pulse; `core_start` drops asynchronously.

## Structure
- Shared package `miner_pkg`:
  - State enum `dispatch_state_t` {IDLE, ISSUE, WAIT, REPORT}.
  - `NONCE_W` = 32.
- Sub-module `miner_stride_counter`, parameters CORES and `NONCE_W`:
  - Inputs: load, `load_value`, `count_enable`.
  - Outputs: count value and `last_flag` (count == 2^NONCE_W − CORES).
  - Increments by CORES with modular wrap.
- Parent contents: FSM, done/found masks, priority encoder.

## Test plan
1. **Hit in round 3.** CORES=4, start 0; cores answer `core_done`=1111 each round; `core_found`=0010 in round 3. Required: `base_nonce` goes 0, 4, 8; `result_valid` pulses once; `result_found`=1; `result_nonce`=9.
2. **Multiple hits, staggered completion.** Start 0x100; in round 1 `core_done` arrives 0001, 1000, 0110 over three cycles, with found on cores 1 and 2. Required: `result_nonce`=0x101; no `result_valid` until the final done bit.
3. **Exhaustion with wrap.**
   - Start 0xFFFFFFF8, no hits → two rounds (0xFFFFFFF8, 0xFFFFFFFC), then `result_found`=0 and `result_nonce`=0.
   - Start 0xFFFFFFFE → aligned to 0xFFFFFFFC, one round only.
4. **Abort.** `abort` in WAIT → IDLE next cycle, `job_ready`=1, no `result_valid`; the previous result is unchanged. `abort` in the same cycle as the final `core_done` → also no result.
5. **Ignored inputs.** `job_valid` pulses during WAIT are ignored; `base_nonce` is undisturbed. `core_done` during IDLE does not start anything.
6. **Reset mid-round.** `n_rst` low during WAIT → all outputs at their reset values immediately. A new job afterwards runs normally from its own start nonce.

Source files
------------

// File: rtl/miner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : miner_pkg
// Brief    : Shared types, widths and helpers for the miner dispatch slice.
// Revision : 1.0 - initial release
// ============================================================================
package miner_pkg;

    localparam int NONCE_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } dispatch_state_t;

    // Index of the lowest set bit; callers guard the all-zero case themselves.
    function automatic logic [5:0] lowest_set_idx(input logic [63:0] vec);
        lowest_set_idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_set_idx = 6'(i);
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/miner_stride_counter.sv
`default_nettype none
// ============================================================================
// Module   : miner_stride_counter
// Brief    : Loadable nonce counter stepping by CORES, with last-stride flag.
// Revision : 1.0 - initial release
// ============================================================================
module miner_stride_counter #(
    parameter int CORES   = 4,
    parameter int NONCE_W = miner_pkg::NONCE_W
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               load,
    input  logic [NONCE_W-1:0] load_value,
    input  logic               count_enable,
    output logic [NONCE_W-1:0] count,
    output logic               last_flag
);

    localparam logic [NONCE_W-1:0] c_stride = NONCE_W'(CORES);
    // 2^NONCE_W - CORES, computed modulo the counter width
    localparam logic [NONCE_W-1:0] c_last   = '0 - c_stride;

    logic [NONCE_W-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (count_enable) begin
            r_count <= r_count + c_stride;
        end
    end

    assign count     = r_count;
    assign last_flag = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/miner_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : miner_dispatch
// Brief    : Round-based nonce scheduler launching CORES hashers in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module miner_dispatch
    import miner_pkg::*;
#(
    parameter int CORES = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               job_valid,
    input  logic [NONCE_W-1:0] job_start_nonce,
    input  logic               abort,
    output logic               job_ready,
    output logic               busy,
    output logic [CORES-1:0]   core_start,
    output logic [NONCE_W-1:0] base_nonce,
    input  logic [CORES-1:0]   core_done,
    input  logic [CORES-1:0]   core_found,
    output logic               result_valid,
    output logic               result_found,
    output logic [NONCE_W-1:0] result_nonce
);

    localparam logic [NONCE_W-1:0] c_align_mask = ~(NONCE_W'(CORES - 1));

    dispatch_state_t    r_state;
    logic               r_job_ready;
    logic               r_busy;
    logic [CORES-1:0]   r_core_start;
    logic               r_result_valid;
    logic               r_result_found;
    logic [NONCE_W-1:0] r_result_nonce;
    logic [CORES-1:0]   r_done_mask;
    logic [CORES-1:0]   r_found_mask;

    logic [CORES-1:0]   w_done_all;
    logic [CORES-1:0]   w_found_all;
    logic [63:0]        w_found_ext;
    logic [5:0]         w_hit_idx;
    logic               w_round_done;
    logic               w_hit;
    logic               w_last;
    logic               w_load;
    logic               w_advance;

    // Completion looks at registered plus same-cycle bits so combinational cores finish in one WAIT cycle
    always_comb begin
        w_done_all               = r_done_mask | core_done;
        w_found_all              = r_found_mask | (core_done & core_found);
        w_found_ext              = '0;
        w_found_ext[CORES-1:0]   = w_found_all;
    end

    assign w_hit_idx    = lowest_set_idx(w_found_ext);
    assign w_round_done = &w_done_all;
    assign w_hit        = |w_found_all;
    assign w_load       = (r_state == IDLE) && job_valid;
    assign w_advance    = (r_state == WAIT) && !abort && w_round_done && !w_hit && !w_last;

    miner_stride_counter #(
        .CORES   (CORES),
        .NONCE_W (NONCE_W)
    ) u_stride_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .load         (w_load),
        .load_value   (job_start_nonce & c_align_mask),
        .count_enable (w_advance),
        .count        (base_nonce),
        .last_flag    (w_last)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state        <= IDLE;
            r_job_ready    <= 1'b1;
            r_busy         <= 1'b0;
            r_core_start   <= '0;
            r_result_valid <= 1'b0;
            r_result_found <= 1'b0;
            r_result_nonce <= '0;
            r_done_mask    <= '0;
            r_found_mask   <= '0;
        end else begin
            r_core_start   <= '0;
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (job_valid) begin
                        r_state        <= ISSUE;
                        r_job_ready    <= 1'b0;
                        r_busy         <= 1'b1;
                        r_core_start   <= '1;
                        r_result_found <= 1'b0;
                        r_result_nonce <= '0;
                    end
                end
                ISSUE: begin
                    r_done_mask  <= core_done;
                    r_found_mask <= core_done & core_found;
                    if (abort) begin
                        r_state     <= IDLE;
                        r_job_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        r_state     <= IDLE;
                        r_job_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_done_mask  <= w_done_all;
                        r_found_mask <= w_found_all;
                        if (w_round_done) begin
                            if (w_hit || w_last) begin
                                r_state        <= REPORT;
                                r_busy         <= 1'b0;
                                r_result_valid <= 1'b1;
                                r_result_found <= w_hit;
                                r_result_nonce <= w_hit ? (base_nonce + NONCE_W'(w_hit_idx)) : '0;
                            end else begin
                                r_state      <= ISSUE;
                                r_core_start <= '1;
                            end
                        end
                    end
                end
                REPORT: begin
                    r_state     <= IDLE;
                    r_job_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_job_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign job_ready    = r_job_ready;
    assign busy         = r_busy;
    assign core_start   = r_core_start;
    assign result_valid = r_result_valid;
    assign result_found = r_result_found;
    assign result_nonce = r_result_nonce;

endmodule
`default_nettype wire
